// File: rtl/twoc_to_sm_pipe_if.sv
// Stream bundle for the two's-complement to sign-magnitude pipe.
// A transfer on either side happens on a rising edge where valid and ready are both high.
interface twoc_to_sm_pipe_if #(
    parameter int WIDTH = 11
);
    localparam int LZW = $clog2(WIDTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_sat;
    logic             out_valid;
    logic             out_ready;
    logic             out_sign;
    logic [WIDTH-1:0] out_mag;
    logic [LZW-1:0]   out_lz;
    logic             out_min;
    logic             out_zero;

    modport master (
        output in_valid, in_data, in_sat, out_ready,
        input  in_ready, out_valid, out_sign, out_mag, out_lz, out_min, out_zero
    );

    modport slave (
        input  in_valid, in_data, in_sat, out_ready,
        output in_ready, out_valid, out_sign, out_mag, out_lz, out_min, out_zero
    );
endinterface

// File: rtl/twoc_to_sm_pipe.sv
// Two-stage two's-complement to sign-magnitude converter with optional saturation of
// the most-negative code, leading-zero count and valid/ready backpressure.
module twoc_to_sm_pipe #(
    parameter int WIDTH = 11
) (
    input logic               clk,
    input logic               rst_n,
    twoc_to_sm_pipe_if.slave  bus
);
    localparam int LZW = $clog2(WIDTH + 1);

    logic             s1_valid_q, s1_valid_d;
    logic             s1_sign_q, s1_sign_d;
    logic [WIDTH-1:0] s1_mag_q, s1_mag_d;
    logic             s1_min_q, s1_min_d;
    logic             s1_zero_q, s1_zero_d;

    logic             s2_valid_q, s2_valid_d;
    logic             s2_sign_q, s2_sign_d;
    logic [WIDTH-1:0] s2_mag_q, s2_mag_d;
    logic [LZW-1:0]   s2_lz_q, s2_lz_d;
    logic             s2_min_q, s2_min_d;
    logic             s2_zero_q, s2_zero_d;

    logic             s2_load, s1_adv, in_ready_c, in_fire;
    logic             in_sign, in_min, in_zero;
    logic [WIDTH-1:0] in_mag;

    function automatic logic [LZW-1:0] count_lz(input logic [WIDTH-1:0] v);
        logic [LZW-1:0] n;
        logic           seen;
        n    = '0;
        seen = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (v[i]) seen = 1'b1;
            else if (!seen) n = n + LZW'(1);
        end
        return n;
    endfunction

    always_comb begin
        s2_load    = ~s2_valid_q | bus.out_ready;
        s1_adv     = s1_valid_q & s2_load;
        in_ready_c = ~s1_valid_q | s2_load;
        in_fire    = bus.in_valid & in_ready_c;

        in_sign = bus.in_data[WIDTH-1];
        in_zero = (bus.in_data == '0);
        in_min  = in_sign & (bus.in_data[WIDTH-2:0] == '0);
        in_mag  = in_sign ? (~bus.in_data + WIDTH'(1)) : bus.in_data;
        // Most-negative code has no positive twin: keep 2^(W-1) or clamp to 2^(W-1)-1.
        if (in_min) begin
            in_mag = bus.in_sat ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_mag_d   = s1_mag_q;
        s1_min_d   = s1_min_q;
        s1_zero_d  = s1_zero_q;
        if (s1_adv) s1_valid_d = 1'b0;
        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_sign_d  = in_sign;
            s1_mag_d   = in_mag;
            s1_min_d   = in_min;
            s1_zero_d  = in_zero;
        end

        s2_valid_d = s2_valid_q;
        s2_sign_d  = s2_sign_q;
        s2_mag_d   = s2_mag_q;
        s2_lz_d    = s2_lz_q;
        s2_min_d   = s2_min_q;
        s2_zero_d  = s2_zero_q;
        if (s2_load) s2_valid_d = s1_valid_q;
        if (s1_adv) begin
            s2_sign_d = s1_sign_q;
            s2_mag_d  = s1_mag_q;
            s2_lz_d   = count_lz(s1_mag_q);
            s2_min_d  = s1_min_q;
            s2_zero_d = s1_zero_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_mag_q   <= '0;
            s1_min_q   <= 1'b0;
            s1_zero_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_sign_q  <= 1'b0;
            s2_mag_q   <= '0;
            s2_lz_q    <= '0;
            s2_min_q   <= 1'b0;
            s2_zero_q  <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_sign_q  <= s1_sign_d;
            s1_mag_q   <= s1_mag_d;
            s1_min_q   <= s1_min_d;
            s1_zero_q  <= s1_zero_d;
            s2_valid_q <= s2_valid_d;
            s2_sign_q  <= s2_sign_d;
            s2_mag_q   <= s2_mag_d;
            s2_lz_q    <= s2_lz_d;
            s2_min_q   <= s2_min_d;
            s2_zero_q  <= s2_zero_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = s2_valid_q;
    assign bus.out_sign  = s2_sign_q;
    assign bus.out_mag   = s2_mag_q;
    assign bus.out_lz    = s2_lz_q;
    assign bus.out_min   = s2_min_q;
    assign bus.out_zero  = s2_zero_q;
endmodule

// File: tb/tb_twoc_to_sm_pipe.sv
// Scoreboard bench for twoc_to_sm_pipe: expected results are pushed when an input is
// accepted and popped by an independent output monitor.
module tb_twoc_to_sm_pipe;
  localparam int W   = 11;
  localparam int LZW = $clog2(W + 1);
  localparam int EW  = W + LZW + 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  twoc_to_sm_pipe_if #(.WIDTH(W)) bus();
  twoc_to_sm_pipe #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [EW-1:0] exp_q[$];
  int            acc_q[$];
  int            n_cmp = 0;
  int            n_err = 0;
  int            cyc = 0;
  int            n_out = 0;
  bit            rand_ready = 1'b0;
  bit            lat_check = 1'b0;
  bit            stall_prev = 1'b0;
  logic [EW-1:0] held;

  // Reference: signed value -> sign, |value| (clamped if requested), leading zeros.
  function automatic logic [EW-1:0] model(input logic [W-1:0] d, input logic sat);
    int   v, m, lz;
    logic sg, mn, z;
    v  = (int'(d) >= (1 << (W - 1))) ? int'(d) - (1 << W) : int'(d);
    sg = (v < 0);
    m  = sg ? -v : v;
    mn = (v == -(1 << (W - 1)));
    z  = (v == 0);
    if (mn && sat) m = (1 << (W - 1)) - 1;
    lz = W;
    for (int k = 0; k < W; k++) if (m >= (1 << k)) lz = W - 1 - k;
    return {sg, m[W-1:0], lz[LZW-1:0], mn, z};
  endfunction

  function automatic logic [EW-1:0] out_bundle();
    return {bus.out_sign, bus.out_mag, bus.out_lz, bus.out_min, bus.out_zero};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Input side of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && bus.in_valid && bus.in_ready) begin
      exp_q.push_back(model(bus.in_data, bus.in_sat));
      acc_q.push_back(cyc + 1);
    end
  end

  // Output monitor.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    int            a;
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", 32'(bus.out_valid), 32'd1);
        check("hold_data", 32'(out_bundle()), 32'(held));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL spurious_output: got %0h expected none", out_bundle());
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          n_out++;
          check("result", 32'(out_bundle()), 32'(e));
          if (lat_check) check("latency", 32'(cyc), 32'(a + 1));
        end
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      held       = out_bundle();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send(input logic [W-1:0] d, input logic s);
    int guard = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_sat   = s;
    @(negedge clk);
    while (!bus.in_ready && guard < 200) begin
      tick();
      @(negedge clk);
      guard++;
    end
    if (!bus.in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: in_ready stuck at 0 for data %0h", d);
    end
    tick();
  endtask

  task automatic drain();
    int g = 0;
    bus.in_valid = 1'b0;
    while ((exp_q.size() != 0 || bus.out_valid) && g < 200) begin
      tick();
      g++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int            base, acc, idx;
    logic [W-1:0]  stall_data [3];
    logic [W-1:0]  r;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_sat    = 1'b0;
    bus.out_ready = 1'b0;
    stall_data    = '{11'h155, 11'h6AB, 11'h010};

    #12;
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_outputs", 32'(out_bundle()), 32'd0);
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Special values with the sink always ready.
    bus.out_ready = 1'b1;
    lat_check     = 1'b1;
    send(11'h000, 1'b0);
    send(11'h7FF, 1'b0);
    send(11'h3FF, 1'b0);
    send(11'h400, 1'b0);
    send(11'h400, 1'b1);
    send(11'h401, 1'b1);
    drain();

    // Back-to-back stream.
    base = n_out;
    for (int i = 1; i <= 8; i++) send(W'(i), 1'b0);
    drain();
    check("stream_count", 32'(n_out - base), 32'd8);
    lat_check = 1'b0;

    // Sink stalled for five cycles while three inputs are offered.
    base          = n_out;
    acc           = 0;
    idx           = 0;
    bus.out_ready = 1'b0;
    repeat (5) begin
      bus.in_valid = 1'b1;
      bus.in_data  = stall_data[idx];
      bus.in_sat   = 1'b0;
      @(negedge clk);
      if (bus.in_ready) begin
        acc++;
        if (idx < 2) idx++;
      end
      tick();
    end
    check("stall_accepted", 32'(acc), 32'd2);
    check("stall_in_ready", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    send(stall_data[2], 1'b0);
    drain();
    check("stall_count", 32'(n_out - base), 32'd3);

    // Asynchronous reset with both stages full.
    bus.out_ready = 1'b0;
    send(11'h123, 1'b0);
    send(11'h7F0, 1'b1);
    bus.in_valid = 1'b0;
    #2;
    check("full_out_valid", 32'(bus.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(bus.out_valid), 32'd0);
    check("async_rst_outputs", 32'(out_bundle()), 32'd0);
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    tick();
    bus.out_ready = 1'b1;
    lat_check     = 1'b1;
    base          = n_out;
    send(11'h2AA, 1'b0);
    drain();
    check("post_reset_count", 32'(n_out - base), 32'd1);
    lat_check = 1'b0;

    // Randomised traffic with random backpressure.
    rand_ready = 1'b1;
    base       = n_out;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 7))
        0:       r = 11'h000;
        1:       r = 11'h400;
        2:       r = 11'h7FF;
        3:       r = 11'h3FF;
        4:       r = 11'h001;
        default: r = W'($urandom_range(0, (1 << W) - 1));
      endcase
      idle($urandom_range(0, 1));
      send(r, 1'($urandom_range(0, 1)));
    end
    drain();
    check("random_count", 32'(n_out - base), 32'd300);
    rand_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
